dwt53_lift_1d: RTL and testbench



---
 rtl/dwt53_lift_1d.sv | 130 +++++++++++++
 tb/tb_dwt53_lift_1d.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dwt53_lift_1d.sv
// Streaming 1-D LeGall 5/3 lifting wavelet: interleaved s/d coefficients per line, mirrored edges.
// Optional DWT53_BYPASS_EN adds a per-line bypass input that passes raw even/odd samples through.
module dwt53_lift_1d #(
  parameter int DW       = 8,
  parameter int LINE_LEN = 64,
  parameter int CW       = $clog2(LINE_LEN)
) (
  input  logic          clk,
  input  logic          rst,
`ifdef DWT53_BYPASS_EN
  input  logic          bypass,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW+1:0] out_data,
  output logic          out_is_high,
  output logic          out_last
);

  localparam int IW = DW + 3;
  localparam logic signed [IW-1:0] TWO = IW'(2);

  typedef enum logic [1:0] {EMPTY, S_BEAT, D_BEAT} ostate_t;

  ostate_t              state_q, state_d;
  logic [CW-1:0]        pos_q;
  logic [DW-1:0]        xe_q, xo_q;
  logic signed [IW-1:0] dprev_q;
  logic [DW+1:0]        s_q, d_q;
  logic                 last_q;

  logic                 pos_is_first, pos_is_final, gen_pos;
  logic                 d_hs, in_fire, gen;
  logic signed [IW-1:0] x_cur, xe_w, xo_w, odd_w, right_w, d_w, dl_w, s_w;
  logic [DW+1:0]        s_sel, d_sel;

  assign pos_is_first = (pos_q == '0);
  assign pos_is_final = (pos_q == CW'(LINE_LEN - 1));
  // Every even sample except x[0] closes a pair, and so does the last (odd) sample.
  assign gen_pos      = (!pos_q[0] && !pos_is_first) || pos_is_final;

  assign d_hs     = (state_q == D_BEAT) && out_ready;
  assign in_ready = !(gen_pos && (state_q != EMPTY) && !d_hs);
  assign in_fire  = in_valid && in_ready;
  assign gen      = in_fire && gen_pos;

  assign x_cur = $signed({3'b000, in_data});
  assign xe_w  = $signed({3'b000, xe_q});
  assign xo_w  = $signed({3'b000, xo_q});

  // Final pair: the current sample is the odd one and x[LINE_LEN] mirrors to x[LINE_LEN-2].
  assign odd_w   = pos_is_final ? x_cur : xo_w;
  assign right_w = pos_is_final ? xe_w  : x_cur;
  assign d_w     = odd_w - ((xe_w + right_w) >>> 1);
  assign dl_w    = (pos_q == CW'(2)) ? d_w : dprev_q;
  assign s_w     = xe_w + ((dl_w + d_w + TWO) >>> 2);

`ifdef DWT53_BYPASS_EN
  logic byp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_q <= 1'b0;
    end else if (in_fire && pos_is_first) begin
      byp_q <= bypass;
    end
  end

  assign s_sel = byp_q ? {2'b00, xe_q}      : s_w[DW+1:0];
  assign d_sel = byp_q ? odd_w[DW+1:0]      : d_w[DW+1:0];
`else
  assign s_sel = s_w[DW+1:0];
  assign d_sel = d_w[DW+1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q   <= '0;
      xe_q    <= '0;
      xo_q    <= '0;
      dprev_q <= '0;
    end else if (in_fire) begin
      pos_q <= pos_is_final ? '0 : pos_q + CW'(1);
      if (!pos_q[0]) begin
        xe_q <= in_data;
      end else begin
        xo_q <= in_data;
      end
      if (gen) begin
        dprev_q <= d_w;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      s_q     <= '0;
      d_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gen) begin
        s_q    <= s_sel;
        d_q    <= d_sel;
        last_q <= pos_is_final;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (gen) state_d = S_BEAT;
      S_BEAT:  if (out_ready) state_d = D_BEAT;
      D_BEAT:  if (out_ready) state_d = gen ? S_BEAT : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  assign out_valid   = (state_q != EMPTY);
  assign out_is_high = (state_q == D_BEAT);
  assign out_last    = out_is_high && last_q;
  assign out_data    = (state_q == S_BEAT) ? s_q :
                       (state_q == D_BEAT) ? d_q : '0;

endmodule

// File: tb/tb_dwt53_lift_1d.sv
// Directed bench for dwt53_lift_1d: three instances (LINE_LEN 4, 8, 64) selected by sel.
module tb_dwt53_lift_1d;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       byp = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b0;
  logic       iv [3];
  logic       ir [3];
  logic       ov [3];
  logic [9:0] od [3];
  logic       oh [3];
  logic       ol [3];

  int n_checks = 0;
  int n_fail   = 0;

  int stim    [0:127];
  int exp_d   [0:127];
  int exp_h   [0:127];
  int exp_l   [0:127];
  int got_d   [0:127];
  int got_raw [0:127];
  int got_h   [0:127];
  int got_l   [0:127];
  int got_cyc [0:127];
  int acc_cyc [0:127];
  int nb;

  always #5 clk = ~clk;

  dwt53_lift_1d #(.DW(8), .LINE_LEN(4)) u4 (
    .clk(clk), .rst(rst),
`ifdef DWT53_BYPASS_EN
    .bypass(byp),
`endif
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_is_high(oh[0]), .out_last(ol[0]));

  dwt53_lift_1d #(.DW(8), .LINE_LEN(8)) u8 (
    .clk(clk), .rst(rst),
`ifdef DWT53_BYPASS_EN
    .bypass(byp),
`endif
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_is_high(oh[1]), .out_last(ol[1]));

  dwt53_lift_1d #(.DW(8), .LINE_LEN(64)) u64 (
    .clk(clk), .rst(rst),
`ifdef DWT53_BYPASS_EN
    .bypass(byp),
`endif
    .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .out_is_high(oh[2]), .out_last(ol[2]));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drives nsamp samples into instance sel and collects beats until nbeats arrive.
  // rmode: 0 = out_ready held 1, 1 = pseudo-random, 2 = held 0.
  task automatic run(input int sel, input int nsamp, input int nbeats, input int rmode);
    int idx = 0;
    int cyc = 0;
    int llen;
    int pos;
    bit gp, prev_stall;
    int pdata, phigh, plast;
    llen = (sel == 0) ? 4 : (sel == 1) ? 8 : 64;
    prev_stall = 1'b0;
    pdata = 0; phigh = 0; plast = 0;
    nb = 0;
    while ((idx < nsamp || nb < nbeats) && cyc < 3000) begin
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      in_data   = 8'(stim[idx < nsamp ? idx : 0]);
      for (int k = 0; k < 3; k++) iv[k] = (k == sel) && (idx < nsamp);
      #1;
      if (prev_stall) begin
        check("stall_valid", int'(ov[sel]), 1);
        check("stall_data",  int'($signed(od[sel])), pdata);
        check("stall_high",  int'(oh[sel]), phigh);
        check("stall_last",  int'(ol[sel]), plast);
      end
      if (idx < nsamp) begin
        pos = idx % llen;
        gp  = (pos != 0 && pos % 2 == 0) || pos == llen - 1;
        check("in_ready_rule", int'(ir[sel]), int'(!(gp && ov[sel] && !(oh[sel] && out_ready))));
        if (ir[sel]) begin
          acc_cyc[idx] = cyc;
          idx++;
        end
      end
      if (ov[sel] && out_ready) begin
        got_d[nb]   = int'($signed(od[sel]));
        got_raw[nb] = int'(od[sel]);
        got_h[nb]   = int'(oh[sel]);
        got_l[nb]   = int'(ol[sel]);
        got_cyc[nb] = cyc;
        nb++;
      end
      prev_stall = ov[sel] && !out_ready;
      pdata = int'($signed(od[sel]));
      phigh = int'(oh[sel]);
      plast = int'(ol[sel]);
      @(negedge clk);
      cyc++;
    end
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    check("run_complete", int'(idx == nsamp && nb == nbeats), 1);
  endtask

  task automatic check_beats(input int n);
    for (int b = 0; b < n; b++) begin
      check("beat_data", got_d[b], exp_d[b]);
      check("beat_high", got_h[b], exp_h[b]);
      check("beat_last", got_l[b], exp_l[b]);
    end
  endtask

  task automatic set4(input int a, input int b, input int c, input int d);
    stim[0] = a; stim[1] = b; stim[2] = c; stim[3] = d;
  endtask

  task automatic exp4(input int a, input int b, input int c, input int d);
    exp_d[0] = a; exp_d[1] = b; exp_d[2] = c; exp_d[3] = d;
    for (int b2 = 0; b2 < 4; b2++) begin
      exp_h[b2] = b2 % 2;
      exp_l[b2] = (b2 == 3) ? 1 : 0;
    end
  endtask

  // Golden lifting model for one line held in stim[0..len-1].
  task automatic gold(input int len);
    int dv [0:63];
    int xe, xo, xn, dl;
    for (int n = 0; n < len / 2; n++) begin
      xe = stim[2*n];
      xo = stim[2*n+1];
      xn = (2*n + 2 < len) ? stim[2*n+2] : stim[len-2];
      dv[n] = xo - ((xe + xn) >>> 1);
    end
    for (int n = 0; n < len / 2; n++) begin
      dl = (n == 0) ? dv[0] : dv[n-1];
      exp_d[2*n]   = stim[2*n] + ((dl + dv[n] + 2) >>> 2);
      exp_d[2*n+1] = dv[n];
      exp_h[2*n]   = 0;
      exp_h[2*n+1] = 1;
      exp_l[2*n]   = 0;
      exp_l[2*n+1] = (n == len / 2 - 1) ? 1 : 0;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_out_valid", int'(ov[k]), 0);
      check("rst_out_data",  int'(od[k]), 0);
      check("rst_is_high",   int'(oh[k]), 0);
      check("rst_last",      int'(ol[k]), 0);
      check("rst_in_ready",  int'(ir[k]), 1);
    end
    @(negedge clk);

    // Basic 4-sample line.
    set4(145, 56, 49, 89);
    exp4(125, -41, 49, 40);
    run(0, 4, 4, 0);
    check_beats(4);
    check("first_s_latency", got_cyc[0], acc_cyc[2] + 1);
    $display("line L=4 145,56,49,89 beats=%0d", nb);

    // Two constant lines back-to-back on LINE_LEN=8.
    for (int i = 0; i < 16; i++) stim[i] = 100;
    for (int b = 0; b < 16; b++) begin
      exp_d[b] = (b % 2 == 1) ? 0 : 100;
      exp_h[b] = b % 2;
      exp_l[b] = (b == 7 || b == 15) ? 1 : 0;
    end
    run(1, 16, 16, 0);
    check_beats(16);
    check("line1_no_gaps", got_cyc[7] - got_cyc[0], 7);
    $display("two lines L=8 const 100 beats=%0d", nb);

    // Extreme swing: sign extension of negative d.
    set4(255, 0, 255, 0);
    exp4(128, -255, 128, -255);
    run(0, 4, 4, 0);
    check_beats(4);
    check("sext_raw", got_raw[1], 'h301);
    $display("line L=4 255,0,255,0 beats=%0d", nb);

    // Random 64-sample line under pseudo-random backpressure.
    for (int i = 0; i < 64; i++) stim[i] = int'($urandom_range(0, 255));
    gold(64);
    run(2, 64, 64, 1);
    check_beats(64);
    $display("line L=64 random backpressure beats=%0d", nb);

    // Asynchronous reset mid-line, with a pair left pending.
    set4(10, 20, 30, 40);
    run(0, 3, 0, 2);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("midrst_out_valid", int'(ov[0]), 0);
    check("midrst_in_ready",  int'(ir[0]), 1);
    @(negedge clk);
    set4(145, 56, 49, 89);
    exp4(125, -41, 49, 40);
    run(0, 4, 4, 0);
    check_beats(4);
    for (int c = 0; c < 4; c++) begin
      out_ready = 1'b1;
      #1;
      check("midrst_no_extra", int'(ov[0]), 0);
      @(negedge clk);
    end
    $display("reset mid-line then 145,56,49,89 beats=%0d", nb);

`ifdef DWT53_BYPASS_EN
    byp = 1'b1;
    set4(145, 56, 49, 89);
    exp4(145, 56, 49, 89);
    run(0, 4, 4, 0);
    check_beats(4);
    $display("bypass line beats=%0d", nb);
    byp = 1'b0;
    exp4(125, -41, 49, 40);
    run(0, 4, 4, 0);
    check_beats(4);
    $display("post-bypass transform line beats=%0d", nb);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
